// File: rtl/layer1_sequencer_pkg.sv
// Shared definitions for the Layer-1 sequencer: network geometry defaults,
// FSM state encoding and the registered control payload.
package layer1_sequencer_pkg;

    // Network geometry (one weight row holds every ReLU node's weight).
    localparam int unsigned RELU_NODES          = 4;
    localparam int unsigned LAYER_1_BIT_WIDTH   = 8;
    localparam int unsigned W_BUS_DEFAULT       = RELU_NODES * LAYER_1_BIT_WIDTH;

    // Pass geometry defaults.
    localparam int unsigned N_INPUTS_DEFAULT    = 784;
    localparam int unsigned ADDR_WIDTH_DEFAULT  = 10;
    localparam int unsigned ROM_LATENCY_DEFAULT = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BIAS  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_ACCUM = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_e;

    // Registered control strobes toward pStore and the network FSM.
    typedef struct packed {
        logic acc_clr;
        logic bias_write_enable;
        logic busy;
        logic done;
    } seq_ctrl_t;

    // Width of a counter that must reach n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer1_sequencer_if.sv
// Bundle of the sequencer's handshake (network FSM side) and datapath
// (weight ROM / pStore side) signals.
//   slave  : the sequencer itself
//   master : the surrounding network FSM / ROM / pStore environment
interface layer1_sequencer_if
    import layer1_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int unsigned W_BUS      = W_BUS_DEFAULT
) ();

    // network FSM handshake
    logic                  start;
    logic                  load_bias;
    logic                  abort;
    logic                  busy;
    logic                  done;
    // weight ROM / pixel source
    logic [ADDR_WIDTH-1:0] weight_addr;
    logic [W_BUS-1:0]      rom_weights;
    logic                  pixel_in;
    // pStore bank
    logic [W_BUS-1:0]      weights_out_c;
    logic                  acc_clr;
    logic                  bias_write_enable;

    modport slave (
        input  start, load_bias, abort, rom_weights, pixel_in,
        output busy, done, weight_addr, weights_out_c, acc_clr, bias_write_enable
    );

    modport master (
        output start, load_bias, abort, rom_weights, pixel_in,
        input  busy, done, weight_addr, weights_out_c, acc_clr, bias_write_enable
    );

endinterface

// File: rtl/layer1_valid_pipe.sv
// DEPTH-deep valid shift register that aligns an "address issued" flag with
// data returning from a fixed-latency memory. flush_i clears every stage.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush_i    : synchronous clear of all stages
//   valid_i    : flag for the address issued this cycle
//   valid_o    : flag delayed by DEPTH cycles
module layer1_valid_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush_i,
    input  logic valid_i,
    output logic valid_o
);

    logic [DEPTH-1:0] pipe_q;

    // Shift toward the MSB; a flush wins over the shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else if (flush_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= valid_i;
            for (int k = 1; k < int'(DEPTH); k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    assign valid_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/layer1_sequencer.sv
// Sequences one Layer-1 inference pass through the pStore accumulator bank:
// optional bias strobe, accumulator clear, then one weight ROM address per
// input pixel, with weights passed to pStore only for set pixels.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   seq_if     : slave side of layer1_sequencer_if
//                start/load_bias/abort in, busy/done out (network FSM)
//                weight_addr out, rom_weights/pixel_in in (ROM, ROM_LATENCY late)
//                weights_out_c/acc_clr/bias_write_enable out (pStore)
module layer1_sequencer
    import layer1_sequencer_pkg::*;
#(
    parameter int unsigned N_INPUTS    = N_INPUTS_DEFAULT,
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
    parameter int unsigned ROM_LATENCY = ROM_LATENCY_DEFAULT,
    parameter int unsigned W_BUS       = W_BUS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    layer1_sequencer_if.slave     seq_if
);

    localparam int unsigned           CNT_W      = cnt_width(ROM_LATENCY);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(N_INPUTS - 1);
    localparam logic [CNT_W-1:0]      LAST_DRAIN = CNT_W'(ROM_LATENCY - 1);

    seq_state_e            state_q;
    seq_ctrl_t             ctrl_q;
    logic [ADDR_WIDTH-1:0] weight_addr_q;
    logic [ADDR_WIDTH-1:0] weight_addr_d;
    logic [CNT_W-1:0]      drain_cnt_q;
    logic                  abort_c;
    logic                  gate_c;

    // Abort only matters while a pass is in flight.
    assign abort_c = seq_if.abort && (state_q != ST_IDLE);

    // Address advances but never wraps past the last pixel.
    assign weight_addr_d = (weight_addr_q == LAST_ADDR) ? weight_addr_q
                                                        : weight_addr_q + ADDR_WIDTH'(1);

    // Pass control FSM; strobes are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ctrl_q        <= '0;
            weight_addr_q <= '0;
            drain_cnt_q   <= '0;
        end else begin
            ctrl_q.acc_clr           <= 1'b0;
            ctrl_q.bias_write_enable <= 1'b0;
            ctrl_q.done              <= 1'b0;
            if (abort_c) begin
                state_q     <= ST_IDLE;
                ctrl_q.busy <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (seq_if.start) begin
                            ctrl_q.busy <= 1'b1;
                            if (seq_if.load_bias) begin
                                state_q                  <= ST_BIAS;
                                ctrl_q.bias_write_enable <= 1'b1;
                            end else begin
                                state_q        <= ST_CLEAR;
                                ctrl_q.acc_clr <= 1'b1;
                            end
                        end
                    end
                    ST_BIAS: begin
                        state_q        <= ST_CLEAR;
                        ctrl_q.acc_clr <= 1'b1;
                    end
                    ST_CLEAR: begin
                        state_q       <= ST_ACCUM;
                        weight_addr_q <= '0;
                    end
                    ST_ACCUM: begin
                        weight_addr_q <= weight_addr_d;
                        if (weight_addr_q == LAST_ADDR) begin
                            state_q     <= ST_DRAIN;
                            drain_cnt_q <= '0;
                        end
                    end
                    ST_DRAIN: begin
                        // Wait until the last issued row has reached pStore.
                        if (drain_cnt_q == LAST_DRAIN) begin
                            state_q     <= ST_DONE;
                            ctrl_q.done <= 1'b1;
                        end else begin
                            drain_cnt_q <= drain_cnt_q + CNT_W'(1);
                        end
                    end
                    ST_DONE: begin
                        state_q     <= ST_IDLE;
                        ctrl_q.busy <= 1'b0;
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        ctrl_q.busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Gate is high exactly when ROM data for an issued address is present.
    layer1_valid_pipe #(
        .DEPTH   (ROM_LATENCY)
    ) u_valid_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (abort_c),
        .valid_i (state_q == ST_ACCUM),
        .valid_o (gate_c)
    );

    // pStore adds on every edge, so zeroing the bus is the only hold.
    assign seq_if.weights_out_c     = (gate_c && seq_if.pixel_in) ? seq_if.rom_weights
                                                                  : W_BUS'(0);
    assign seq_if.weight_addr       = weight_addr_q;
    assign seq_if.acc_clr           = ctrl_q.acc_clr;
    assign seq_if.bias_write_enable = ctrl_q.bias_write_enable;
    assign seq_if.busy              = ctrl_q.busy;
    assign seq_if.done              = ctrl_q.done;

endmodule

// File: tb/tb_layer1_sequencer.sv
// Bench for layer1_sequencer: two instances (ROM latency 1 and 3, 4 pixels),
// a ROM model, a pStore accumulator model, and an event schedule computed
// from the pass timing rules.
module tb_layer1_sequencer;
    import layer1_sequencer_pkg::*;

    localparam int unsigned N     = 4;
    localparam int unsigned AW    = 10;
    localparam int unsigned WB    = W_BUS_DEFAULT;
    localparam int unsigned NODES = RELU_NODES;
    localparam int unsigned LW    = LAYER_1_BIT_WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int   sel     = 0;      // 0: latency-1 instance, 1: latency-3 instance
    logic start_r = 1'b0;
    logic lb_r    = 1'b0;
    logic abort_r = 1'b0;

    logic [WB-1:0] wmem [N];
    logic          pmem [N];
    int            bias_in  [NODES];
    int            bias_cur [NODES];

    int vectors     = 0;
    int miscompares = 0;

    layer1_sequencer_if #(.ADDR_WIDTH(AW), .W_BUS(WB)) if_l1 ();
    layer1_sequencer_if #(.ADDR_WIDTH(AW), .W_BUS(WB)) if_l3 ();

    assign if_l1.start     = start_r && (sel == 0);
    assign if_l1.load_bias = lb_r;
    assign if_l1.abort     = abort_r && (sel == 0);
    assign if_l3.start     = start_r && (sel == 1);
    assign if_l3.load_bias = lb_r;
    assign if_l3.abort     = abort_r && (sel == 1);

    layer1_sequencer #(.N_INPUTS(N), .ADDR_WIDTH(AW), .ROM_LATENCY(1), .W_BUS(WB)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .seq_if(if_l1));
    layer1_sequencer #(.N_INPUTS(N), .ADDR_WIDTH(AW), .ROM_LATENCY(3), .W_BUS(WB)) dut_l3 (
        .clk(clk), .rst_n(rst_n), .seq_if(if_l3));

    // ROM + pixel source models with the matching read latency.
    logic [WB-1:0] r3a, r3b;
    logic          p3a, p3b;
    always @(posedge clk) begin
        if_l1.rom_weights <= wmem[if_l1.weight_addr[1:0]];
        if_l1.pixel_in    <= pmem[if_l1.weight_addr[1:0]];
        r3a <= wmem[if_l3.weight_addr[1:0]];
        p3a <= pmem[if_l3.weight_addr[1:0]];
        r3b <= r3a;
        p3b <= p3a;
        if_l3.rom_weights <= r3b;
        if_l3.pixel_in    <= p3b;
    end

    // Observed outputs of the selected instance.
    logic          o_busy, o_done, o_clr, o_bwe;
    logic [AW-1:0] o_addr;
    logic [WB-1:0] o_w;
    always_comb begin
        if (sel == 0) begin
            o_busy = if_l1.busy; o_done = if_l1.done; o_clr = if_l1.acc_clr;
            o_bwe  = if_l1.bias_write_enable; o_addr = if_l1.weight_addr; o_w = if_l1.weights_out_c;
        end else begin
            o_busy = if_l3.busy; o_done = if_l3.done; o_clr = if_l3.acc_clr;
            o_bwe  = if_l3.bias_write_enable; o_addr = if_l3.weight_addr; o_w = if_l3.weights_out_c;
        end
    end

    function automatic int lane(input logic [WB-1:0] w, input int i);
        logic signed [LW-1:0] v;
        v = w[i*LW +: LW];
        return int'(v);
    endfunction

    function automatic logic [WB-1:0] rep(input int v);
        logic [LW-1:0] b;
        b = LW'(v);
        return {NODES{b}};
    endfunction

    // pStore model: inputs captured mid-cycle, applied on the next edge.
    logic          s_bwe = 1'b0, s_clr = 1'b0;
    logic [WB-1:0] s_w   = '0;
    int            acc      [NODES];
    int            bias_reg [NODES];
    always @(negedge clk) begin
        s_bwe = o_bwe;
        s_clr = o_clr;
        s_w   = o_w;
    end
    always @(posedge clk) begin
        for (int i = 0; i < int'(NODES); i++) begin
            if (s_bwe) bias_reg[i] = bias_in[i];
            if (s_clr) acc[i] = bias_reg[i];
            else       acc[i] = acc[i] + lane(s_w, i);
        end
    end

    // Reference result: bias plus every set pixel's weight.
    function automatic int exp_sum(input int i);
        int s;
        s = bias_cur[i];
        for (int k = 0; k < int'(N); k++) if (pmem[k]) s += lane(wmem[k], i);
        return s;
    endfunction

    // One pass started at cycle 0; every cycle is checked against the schedule.
    task automatic run_pass(input bit lb, input int abort_at, input bit spam,
                            input bit abort_w_start, input string tag);
        int lat, off, dn, k, idx;
        bit ab;
        logic [3:0]    ec, gc;
        logic [WB-1:0] ew;
        logic [AW-1:0] ea;
        lat = (sel == 0) ? 1 : 3;
        off = lb ? 0 : 1;
        dn  = int'(N) + 3 + lat - off;
        @(posedge clk); #1;
        start_r = 1'b1; lb_r = lb; abort_r = abort_w_start;
        if (lb) for (int i = 0; i < int'(NODES); i++) bias_cur[i] = bias_in[i];
        @(negedge clk);
        vectors++;
        if (o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_c0 got=%b want=0", tag, o_busy);
        end
        for (int c = 1; c <= dn + 2; c++) begin
            @(posedge clk); #1;
            start_r = (spam && c < dn) ? 1'($urandom_range(0, 1)) : 1'b0;
            lb_r    = 1'($urandom_range(0, 1));
            abort_r = (c == abort_at);
            @(negedge clk);
            ab = (abort_at >= 0) && (c > abort_at);
            k  = c - (3 - off) - lat;
            ew = '0;
            if (!ab && k >= 0 && k < int'(N)) ew = pmem[k] ? wmem[k] : '0;
            ec = {!ab && c <= dn, !ab && lb && c == 1, !ab && c == 2 - off, !ab && c == dn};
            gc = {o_busy, o_bwe, o_clr, o_done};
            vectors++;
            if (gc !== ec) begin
                miscompares++;
                $display("FAIL %s ctrl c=%0d got{busy,bwe,clr,done}=%b want=%b", tag, c, gc, ec);
            end
            vectors++;
            if (o_w !== ew) begin
                miscompares++;
                $display("FAIL %s weights c=%0d got=%h want=%h", tag, c, o_w, ew);
            end
            if (!ab && c >= 3 - off && c <= dn) begin
                idx = c - (3 - off);
                ea  = AW'((idx < int'(N)) ? idx : int'(N) - 1);
                vectors++;
                if (o_addr !== ea) begin
                    miscompares++;
                    $display("FAIL %s addr c=%0d got=%0d want=%0d", tag, c, o_addr, ea);
                end
            end
            if (abort_at < 0 && c >= dn) begin
                for (int i = 0; i < int'(NODES); i++) begin
                    vectors++;
                    if (acc[i] !== exp_sum(i)) begin
                        miscompares++;
                        $display("FAIL %s sum c=%0d node=%0d got=%0d want=%0d", tag, c, i, acc[i], exp_sum(i));
                    end
                end
            end
        end
        start_r = 1'b0;
        abort_r = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({if_l1.busy, if_l1.done, if_l1.acc_clr, if_l1.bias_write_enable} !== 4'b0 ||
            if_l1.weight_addr !== '0 || if_l1.weights_out_c !== '0) begin
            miscompares++;
            $display("FAIL reset_l1 got busy=%b done=%b addr=%0d w=%h want all 0",
                     if_l1.busy, if_l1.done, if_l1.weight_addr, if_l1.weights_out_c);
        end
        vectors++;
        if ({if_l3.busy, if_l3.done, if_l3.acc_clr, if_l3.bias_write_enable} !== 4'b0 ||
            if_l3.weight_addr !== '0 || if_l3.weights_out_c !== '0) begin
            miscompares++;
            $display("FAIL reset_l3 got busy=%b done=%b addr=%0d w=%h want all 0",
                     if_l3.busy, if_l3.done, if_l3.weight_addr, if_l3.weights_out_c);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        sel = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            start_r = 1'b0;
            abort_r = 1'($urandom_range(0, 1));
            @(negedge clk);
            vectors++;
            if (o_busy !== 1'b0 || o_done !== 1'b0 || o_w !== '0) begin
                miscompares++;
                $display("FAIL idle c=%0d got busy=%b done=%b w=%h want 0/0/0", c, o_busy, o_done, o_w);
            end
        end
        abort_r = 1'b0;
    endtask

    task automatic set_bias(input int b);
        for (int i = 0; i < int'(NODES); i++) bias_in[i] = b;
    endtask

    task automatic test_full_pass();
        sel = 0;
        set_bias(5);
        for (int k = 0; k < int'(N); k++) begin wmem[k] = rep(1); pmem[k] = 1'b1; end
        run_pass(1'b1, -1, 1'b0, 1'b0, "full_pass");
    endtask

    task automatic test_pixel_masking();
        sel = 0;
        set_bias(5);
        wmem[0] = rep(2); wmem[1] = rep(-3); wmem[2] = rep(4); wmem[3] = rep(-5);
        pmem[0] = 1'b1;   pmem[1] = 1'b0;    pmem[2] = 1'b1;   pmem[3] = 1'b0;
        run_pass(1'b1, -1, 1'b0, 1'b0, "pixel_mask");
        vectors++;
        if (acc[0] !== 11) begin
            miscompares++;
            $display("FAIL pixel_mask_abs got=%0d want=11", acc[0]);
        end
    endtask

    task automatic test_no_bias_reload();
        sel = 0;
        set_bias(99);   // must not be picked up without loadBias
        run_pass(1'b0, -1, 1'b0, 1'b0, "no_bias");
        set_bias(5);
    endtask

    task automatic test_abort();
        sel = 0;
        run_pass(1'b1, 5, 1'b0, 1'b0, "abort");
        run_pass(1'b0, -1, 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_start_with_abort();
        sel = 0;
        run_pass(1'b1, -1, 1'b0, 1'b1, "start_abort_idle");
    endtask

    task automatic test_latency_sweep();
        sel = 1;
        for (int k = 0; k < int'(N); k++) begin wmem[k] = WB'($urandom()); pmem[k] = 1'b1; end
        set_bias(-7);
        run_pass(1'b1, -1, 1'b1, 1'b0, "lat3_lb");
        pmem[1] = 1'b0;
        run_pass(1'b0, -1, 1'b1, 1'b0, "lat3_nolb");
    endtask

    task automatic test_reset_mid_pass();
        sel = 0;
        @(posedge clk); #1;
        start_r = 1'b1; lb_r = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({o_busy, o_done, o_clr, o_bwe} !== 4'b0 || o_addr !== '0 || o_w !== '0) begin
            miscompares++;
            $display("FAIL reset_mid got busy=%b done=%b addr=%0d w=%h want all 0", o_busy, o_done, o_addr, o_w);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (o_busy !== 1'b0 || o_w !== '0) begin
                miscompares++;
                $display("FAIL reset_mid_idle c=%0d got busy=%b w=%h want 0", c, o_busy, o_w);
            end
        end
        run_pass(1'b1, -1, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int p = 0; p < 8; p++) begin
            sel = p % 2;
            for (int k = 0; k < int'(N); k++) begin
                wmem[k] = WB'($urandom());
                pmem[k] = 1'($urandom_range(0, 1));
            end
            for (int i = 0; i < int'(NODES); i++) bias_in[i] = int'($urandom_range(0, 200)) - 100;
            run_pass((p == 0) ? 1'b1 : 1'($urandom_range(0, 1)), -1, 1'b0, 1'b0, "random");
        end
    endtask

    initial begin
        for (int k = 0; k < int'(N); k++) begin wmem[k] = '0; pmem[k] = 1'b0; end
        for (int i = 0; i < int'(NODES); i++) begin
            bias_in[i] = 0; bias_cur[i] = 0; acc[i] = 0; bias_reg[i] = 0;
        end
        test_reset();
        test_idle();
        test_full_pass();
        test_pixel_masking();
        test_no_bias_reload();
        test_abort();
        test_start_with_abort();
        test_latency_sweep();
        test_reset_mid_pass();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/layer1_sequencer.md
Name: layer1_sequencer

Overview:
- Controller that sequences one Layer-1 inference pass through the pStore accumulator bank.
- Optionally strobes new biases into the bank, then clears the accumulators to those biases.
- Walks the weight ROM address over every input pixel and feeds weights into pStore only for pixels that are set.
- Sits between the top-level network FSM (start/done) and the weight ROM plus the pStore bank.

Parameters:
N_INPUTS, 784, input pixels per image (number of accumulate steps)
ADDR_WIDTH, 10, weight ROM address width; must satisfy 2^ADDR_WIDTH >= N_INPUTS
ROM_LATENCY, 1, cycles from weightAddr to romWeights/pixelIn valid (>=1)
W_BUS, `RELU_NODES*`LAYER_1_BIT_WIDTH, packed weight bus width (from GlobalVariables.v)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a pass; sampled only in IDLE
loadBias  input  1  sampled with start; 1 = strobe biases before the clear
abort  input  1  synchronous abort; returns the block to IDLE
romWeights  input  W_BUS  weight row for the address issued ROM_LATENCY cycles earlier
pixelIn  input  1  binarised pixel for the same address, same latency
weightAddr  output  ADDR_WIDTH  ROM/pixel address
weightsOut  output  W_BUS  to pStore weightsIn; romWeights when gated in, else all zeros
accClr  output  1  to pStore clr; 1-cycle pulse
biasWriteEnable  output  1  to pStore biasWriteEnable; 1-cycle pulse
busy  output  1  high in every state except IDLE
done  output  1  1-cycle pulse; pStore sumOut is final during this cycle

Behaviour:
- Reset (rst_n=0): state IDLE. weightAddr=0, accClr=0, biasWriteEnable=0, busy=0, done=0, valid pipeline cleared, weightsOut=0.
- All control outputs are registered. weightsOut = (validPipe[ROM_LATENCY-1] & pixelIn) ? romWeights : 0, combinational from registered gate.
- pStore accumulates on every clk edge. Zeroed weightsOut is therefore the only hold mechanism, and it must be zero in every cycle outside valid accumulate slots.
- FSM states: IDLE, BIAS, CLEAR, ACCUM, DRAIN, DONE.
- IDLE: on start=1, go to BIAS if loadBias=1, else to CLEAR. start in any other state is ignored.
- BIAS: biasWriteEnable=1 for exactly 1 cycle, then CLEAR.
- CLEAR: accClr=1 for exactly 1 cycle, weightAddr<=0, then ACCUM.
- ACCUM: each cycle issues weightAddr and sets validPipe[0]=1. weightAddr increments by 1. After issuing address N_INPUTS-1, go to DRAIN; weightAddr does not wrap and holds N_INPUTS-1.
- DRAIN: validPipe[0]=0. Stays ROM_LATENCY cycles while the last weights are accumulated, then goes to DONE.
- DONE: done=1 for 1 cycle, then IDLE. sumOut is stable from this cycle until the next accClr.
- validPipe: ROM_LATENCY-deep shift register, aligning the gate with ROM data.
- Timing, start accepted at cycle 0 with loadBias=1:
  - BIAS at cycle 1, CLEAR at cycle 2.
  - Addresses issued at cycles 3..N_INPUTS+2.
  - done at cycle N_INPUTS+3+ROM_LATENCY.
  - With loadBias=0, every event after cycle 0 is one cycle earlier.
- abort=1 in any non-IDLE state: next state IDLE, validPipe flushed (weightsOut=0 next cycle), no done pulse, pStore contents undefined. abort in IDLE has no effect. If abort and start are both asserted in IDLE, start wins.
- Reset mid-pass: same as abort, but asynchronous.
- accClr and biasWriteEnable are never high together or in consecutive cycles with start.

Decomposition:
- Shared package/header (GlobalVariables.v): N_INPUTS and ROM_LATENCY defaults as `defines alongside RELU_NODES and LAYER_1_BIT_WIDTH; state encoding localparams.
- Sub-module: layer1_valid_pipe, the ROM_LATENCY-deep valid/flush shift register, reusable for Layer 2 sequencing.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> all outputs 0 immediately; start=0 for 10 cycles -> busy=0, weightsOut=0 throughout.
- Full pass, N_INPUTS=4, ROM_LATENCY=1, loadBias=1, all pixels=1, each node weight=+1, bias=5 -> biasWriteEnable at cycle 1, accClr at cycle 2, addresses 0..3 at cycles 3..6, done at cycle 8, sumOut=9 per node.
- Pixel masking: same setup with pixels 1,0,1,0 and weights +2,-3,+4,-5 (sign-extended) -> sumOut=5+2+4=11 at done; no change on the following idle cycles.
- No bias reload: second pass with loadBias=0 -> no biasWriteEnable pulse, done at cycle 7, previous bias 5 reused.
- Abort during ACCUM at address 2 -> busy=0 next cycle, weightsOut=0, no done. A fresh start then completes normally with correct sum.
- Latency sweep ROM_LATENCY=3, N_INPUTS=4 -> done at cycle 10; weights gated exactly on cycles 6..9; start pulses while busy are ignored.
